// File: rtl/vector_serializer_vs_pkg.sv
// Shared types and helpers for the vector-to-scalar serializer slice.
`define VS_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package vector_serializer_vs_pkg;

  localparam int unsigned DEF_BITWIDTH     = 16;
  localparam int unsigned DEF_N            = 8;
  localparam int unsigned DEF_DEPTH        = 8;
  localparam int unsigned DEF_AFULL_MARGIN = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // One extra bit so a count can represent both empty (0) and full (depth).
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vector_serializer_vs_if.sv
// Vector-in / scalar-out bundle; master is the producer+consumer side, slave is the serializer.
interface vector_serializer_vs_if
  import vector_serializer_vs_pkg::*;
#(
  parameter int unsigned bitwidth = DEF_BITWIDTH,
  parameter int unsigned N        = DEF_N,
  parameter int unsigned DEPTH    = DEF_DEPTH
) ();

  logic [N*bitwidth-1:0]       in_data;
  logic                        in_valid;
  logic                        in_last;
  logic                        in_afull;
  logic                        overflow;
  logic [count_w(DEPTH)-1:0]   fifo_count;
  logic [bitwidth-1:0]         m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last;

  modport master (
    output in_data, in_valid, in_last, m_ready,
    input  in_afull, overflow, fifo_count, m_data, m_valid, m_last
  );

  modport slave (
    input  in_data, in_valid, in_last, m_ready,
    output in_afull, overflow, fifo_count, m_data, m_valid, m_last
  );

endinterface

// File: rtl/vector_serializer_vs_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; writes when full and reads when empty are ignored.
module sync_fifo_vs
  import vector_serializer_vs_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [width-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [width-1:0]            rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [count_w(depth)-1:0]   count
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = count_w(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(depth));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/vector_serializer_vs.sv
// Buffers whole vector beats and replays them lane by lane on a valid/ready/last stream.
module vector_serializer_vs
  import vector_serializer_vs_pkg::*;
#(
  parameter int unsigned bitwidth     = DEF_BITWIDTH,
  parameter int unsigned N            = DEF_N,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned AFULL_MARGIN = DEF_AFULL_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_serializer_vs_if.slave bus
);

  localparam int unsigned VW        = N * bitwidth;
  localparam int unsigned CW        = count_w(DEPTH);
  localparam int unsigned IW        = idx_w(N);
  localparam int unsigned AF_THRESH = (DEPTH > AFULL_MARGIN) ? DEPTH - AFULL_MARGIN : 0;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] hold_vec_q, hold_vec_d;
  logic          hold_last_q, hold_last_d;
  logic          overflow_q, overflow_d;
  logic          afull_q, afull_d;
  logic          pop, wr_ok, fifo_full, fifo_empty;
  logic [VW:0]   rd_data;
  logic [CW-1:0] count, count_d;

  sync_fifo_vs #(
    .width (VW + 1),
    .depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.in_valid),
    .wr_data ({bus.in_last, bus.in_data}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Threshold is evaluated on the count the FIFO will hold after this edge.
  assign wr_ok      = bus.in_valid && !fifo_full;
  assign count_d    = count + CW'(wr_ok) - CW'(pop);
  assign afull_d    = (32'(count_d) >= AF_THRESH);
  assign overflow_d = overflow_q || (bus.in_valid && fifo_full);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_vec_d  = hold_vec_q;
    hold_last_d = hold_last_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (bus.m_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
    if (pop) begin
      hold_last_d = rd_data[VW];
      hold_vec_d  = rd_data[VW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_vec_q  <= '0;
      hold_last_q <= 1'b0;
      overflow_q  <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_vec_q  <= hold_vec_d;
      hold_last_q <= hold_last_d;
      overflow_q  <= overflow_d;
      afull_q     <= afull_d;
    end
  end

  assign bus.m_valid    = (state_q == SEND);
  assign bus.m_data     = `VS_LANE(hold_vec_q, idx_q, bitwidth);
  assign bus.m_last     = (state_q == SEND) && hold_last_q && (idx_q == LAST_IDX);
  assign bus.in_afull   = afull_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_vector_serializer_vs.sv
// Randomized bench for vector_serializer_vs against a queue-level model of vectors and elements.
module tb_vector_serializer_vs;

  localparam int unsigned BW    = 16;
  localparam int unsigned NL    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFM   = 4;
  localparam int unsigned VW    = BW * NL;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_serializer_vs_if #(.bitwidth(BW), .N(NL), .DEPTH(DEPTH)) bus ();

  vector_serializer_vs #(
    .bitwidth     (BW),
    .N            (NL),
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [VW-1:0] d; bit l; } vec_t;
  typedef struct { logic [BW-1:0] d; bit l; } el_t;

  vec_t mq[$];   // vectors waiting in the FIFO
  el_t  mh[$];   // elements still to be sent from the current vector
  bit   movf;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic mdl_reset();
    mq.delete();
    mh.delete();
    movf = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic mdl_step();
    bit   was_full, pop;
    vec_t v, w;
    el_t  e;
    was_full = (mq.size() == DEPTH);
    pop = 1'b0;
    if (mh.size() == 0) begin
      pop = (mq.size() > 0);
    end else if (bus.m_ready) begin
      void'(mh.pop_front());
      pop = (mh.size() == 0) && (mq.size() > 0);
    end
    if (pop) begin
      v = mq.pop_front();
      for (int i = 0; i < NL; i++) begin
        e.d = v.d[i*BW +: BW];
        e.l = v.l && (i == NL - 1);
        mh.push_back(e);
      end
    end
    if (bus.in_valid) begin
      if (was_full) movf = 1'b1;
      else begin
        w.d = bus.in_data;
        w.l = bus.in_last;
        mq.push_back(w);
      end
    end
  endtask

  function automatic bit e_valid();
    return mh.size() > 0;
  endfunction
  function automatic logic [BW-1:0] e_data();
    return (mh.size() > 0) ? mh[0].d : '0;
  endfunction
  function automatic bit e_last();
    return (mh.size() > 0) && mh[0].l;
  endfunction
  function automatic bit e_afull();
    return (DEPTH - mq.size()) <= AFM;
  endfunction

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input bit v, input logic [VW-1:0] d, input bit l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic tick();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    bus.m_ready = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    #1;
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
    n_chk++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got=%b exp=0", bus.m_last); end
    n_chk++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL rst_m_data got=%h exp=0", bus.m_data); end
    n_chk++; if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.fifo_count); end
    n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow); end
    n_chk++; if (bus.in_afull !== 1'b0) begin n_fail++; $display("FAIL rst_afull got=%b exp=0", bus.in_afull); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [VW-1:0] d;
    bit            ev, el;
    logic [BW-1:0] ed;
    for (int i = 0; i < NL; i++) d[i*BW +: BW] = 16'h3C00 + 16'(i);
    bus.m_ready = 1'b1;
    drive(1'b1, d, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_t1 got=%b exp=0", bus.m_valid); end
    tick();
    for (int c = 0; c < 12; c++) begin
      ev = (c < NL);
      ed = 16'h3C00 + 16'(c);
      el = (c == NL - 1);
      n_chk++; if (bus.m_valid !== ev) begin n_fail++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, bus.m_valid, ev); end
      if (ev) begin
        n_chk++; if (bus.m_data !== ed) begin n_fail++; $display("FAIL single_data c=%0d got=%h exp=%h", c, bus.m_data, ed); end
        n_chk++; if (bus.m_last !== el) begin n_fail++; $display("FAIL single_last c=%0d got=%b exp=%b", c, bus.m_last, el); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, lastc = -1, nel = 0, last_at = -1;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) drive(1'b1, rvec(), c == 2);
      else       drive(1'b0, '0, 1'b0);
      if (bus.m_valid) begin
        nel++;
        if (first < 0) first = c;
        lastc = c;
        if (bus.m_last) last_at = nel;
      end
      tick();
      n_chk++; if (bus.m_valid !== e_valid()) begin n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, bus.m_valid, e_valid()); end
      if (e_valid()) begin
        n_chk++; if ({bus.m_data, bus.m_last} !== {e_data(), e_last()}) begin n_fail++; $display("FAIL b2b_elem c=%0d got=%h/%b exp=%h/%b", c, bus.m_data, bus.m_last, e_data(), e_last()); end
      end
    end
    n_chk++; if (nel != 24) begin n_fail++; $display("FAIL b2b_count got=%0d exp=24", nel); end
    n_chk++; if (lastc - first + 1 != 24) begin n_fail++; $display("FAIL b2b_bubble span got=%0d exp=24", lastc - first + 1); end
    n_chk++; if (last_at != 24) begin n_fail++; $display("FAIL b2b_last_pos got=%0d exp=24", last_at); end
  endtask

  task automatic test_backpressure();
    int sent = 0, hs = 0;
    for (int c = 0; c < 120; c++) begin
      bus.m_ready = (c % 4 == 0) || (c % 4 == 3);
      if (c % 3 == 0 && sent < 4) begin
        drive(1'b1, rvec(), sent % 2 == 1);
        sent++;
      end else drive(1'b0, '0, 1'b0);
      if (bus.m_valid && bus.m_ready) hs++;
      tick();
      n_chk++; if (bus.m_valid !== e_valid()) begin n_fail++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, bus.m_valid, e_valid()); end
      if (e_valid()) begin
        n_chk++; if ({bus.m_data, bus.m_last} !== {e_data(), e_last()}) begin n_fail++; $display("FAIL bp_elem c=%0d got=%h/%b exp=%h/%b", c, bus.m_data, bus.m_last, e_data(), e_last()); end
      end
      n_chk++; if (bus.fifo_count !== CW'(mq.size())) begin n_fail++; $display("FAIL bp_count c=%0d got=%0d exp=%0d", c, bus.fifo_count, mq.size()); end
    end
    n_chk++; if (hs != 32) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=32", hs); end
  endtask

  task automatic test_full_pop();
    int lasts = 0;
    apply_reset();
    bus.m_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, rvec(), 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    n_chk++; if (bus.fifo_count !== CW'(8)) begin n_fail++; $display("FAIL fp_pre_count got=%0d exp=8", bus.fifo_count); end
    n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fp_pre_overflow got=%b exp=0", bus.overflow); end
    bus.m_ready = 1'b1;
    repeat (NL - 1) tick();
    drive(1'b1, rvec(), 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    n_chk++; if (bus.fifo_count !== CW'(7)) begin n_fail++; $display("FAIL fp_count got=%0d exp=7", bus.fifo_count); end
    n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL fp_overflow got=%b exp=1", bus.overflow); end
    n_chk++; if (bus.in_afull !== 1'b1) begin n_fail++; $display("FAIL fp_afull got=%b exp=1", bus.in_afull); end
    n_chk++; if ({bus.m_valid, bus.m_data} !== {1'b1, e_data()}) begin n_fail++; $display("FAIL fp_next_vec got=%b/%h exp=1/%h", bus.m_valid, bus.m_data, e_data()); end
    for (int c = 0; c < 100; c++) begin
      if (bus.m_valid && bus.m_last) lasts++;
      tick();
      if (e_valid()) begin
        n_chk++; if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, e_data(), e_last()}) begin n_fail++; $display("FAIL fp_drain c=%0d got=%b/%h/%b exp=1/%h/%b", c, bus.m_valid, bus.m_data, bus.m_last, e_data(), e_last()); end
      end
    end
    n_chk++; if (lasts != 8) begin n_fail++; $display("FAIL fp_vectors got=%0d exp=8", lasts); end
  endtask

  task automatic test_fill();
    int lasts = 0;
    apply_reset();
    bus.m_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c < 10) drive(1'b1, rvec(), 1'b1);
      else        drive(1'b0, '0, 1'b0);
      tick();
      n_chk++; if (bus.fifo_count !== CW'(mq.size())) begin n_fail++; $display("FAIL fill_count c=%0d got=%0d exp=%0d", c, bus.fifo_count, mq.size()); end
      n_chk++; if (bus.in_afull !== e_afull()) begin n_fail++; $display("FAIL fill_afull c=%0d got=%b exp=%b", c, bus.in_afull, e_afull()); end
      n_chk++; if (bus.overflow !== movf) begin n_fail++; $display("FAIL fill_overflow c=%0d got=%b exp=%b", c, bus.overflow, movf); end
    end
    n_chk++; if (bus.fifo_count !== CW'(8)) begin n_fail++; $display("FAIL fill_saturate got=%0d exp=8", bus.fifo_count); end
    n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_sticky got=%b exp=1", bus.overflow); end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (bus.m_valid && bus.m_last) lasts++;
      tick();
      n_chk++; if (bus.m_valid !== e_valid()) begin n_fail++; $display("FAIL fill_drain_valid c=%0d got=%b exp=%b", c, bus.m_valid, e_valid()); end
      if (e_valid()) begin
        n_chk++; if ({bus.m_data, bus.m_last} !== {e_data(), e_last()}) begin n_fail++; $display("FAIL fill_drain_elem c=%0d got=%h/%b exp=%h/%b", c, bus.m_data, bus.m_last, e_data(), e_last()); end
      end
    end
    n_chk++; if (lasts != 9) begin n_fail++; $display("FAIL fill_vectors got=%0d exp=9", lasts); end
    n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_sticky_after got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] d;
    logic [BW-1:0] lane0;
    bus.m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, rvec(), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();
    bus.m_ready = 1'b1;
    repeat (3) tick();
    n_chk++; if ({bus.m_valid, bus.m_data} !== {1'b1, e_data()}) begin n_fail++; $display("FAIL ar_pre_lane3 got=%b/%h exp=1/%h", bus.m_valid, bus.m_data, e_data()); end
    #2;
    rst = 1'b1;
    mdl_reset();
    #1;
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL ar_m_valid got=%b exp=0", bus.m_valid); end
    n_chk++; if (bus.fifo_count !== '0) begin n_fail++; $display("FAIL ar_count got=%0d exp=0", bus.fifo_count); end
    n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ar_overflow got=%b exp=0", bus.overflow); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    d = rvec();
    lane0 = d[BW-1:0];
    drive(1'b1, d, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    n_chk++; if ({bus.m_valid, bus.m_data} !== {1'b1, lane0}) begin n_fail++; $display("FAIL ar_lane0 got=%b/%h exp=1/%h", bus.m_valid, bus.m_data, lane0); end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_chk++; if (bus.m_valid !== e_valid()) begin n_fail++; $display("FAIL ar_valid c=%0d got=%b exp=%b", c, bus.m_valid, e_valid()); end
      if (e_valid()) begin
        n_chk++; if ({bus.m_data, bus.m_last} !== {e_data(), e_last()}) begin n_fail++; $display("FAIL ar_elem c=%0d got=%h/%b exp=%h/%b", c, bus.m_data, bus.m_last, e_data(), e_last()); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_fill();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
